// File: rtl/rc4_phase_ctrl.sv
// rc4_phase_ctrl: sequences the RC4 S-array init, key schedule and keystream
// engines, owns the single S-memory write/address port, and guards every
// working phase with a watchdog that drops the sequence into a sticky error.
module rc4_phase_ctrl #(
    parameter int TIMEOUT = 4096,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset_n,   // synchronous, active-high despite the name
    input  logic          start,
    input  logic          abort,

    output logic          init_rst,
    input  logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    input  logic          init_wren,
    input  logic          init_done,

    output logic          ksa_rst,
    input  logic [AW-1:0] ksa_addr,
    input  logic [DW-1:0] ksa_data,
    input  logic          ksa_wren,
    input  logic          ksa_done,

    output logic          prga_rst,
    input  logic [AW-1:0] prga_addr,
    input  logic [DW-1:0] prga_data,
    input  logic          prga_wren,
    input  logic          prga_done,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,

    output logic [2:0]    phase,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_KSA  = 3'd2,
        S_PRGA = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_wdog;
    logic            w_own_done;
    state_t          w_next_phase;

    // Select the done of whichever engine owns the current phase; others are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_own_done   = 1'b0;
        w_next_phase = S_IDLE;
        case (r_state)
            S_INIT: begin w_own_done = init_done; w_next_phase = S_KSA;  end
            S_KSA:  begin w_own_done = ksa_done;  w_next_phase = S_PRGA; end
            S_PRGA: begin w_own_done = prga_done; w_next_phase = S_DONE; end
            default: ;
        endcase
    end

    // Phase sequencer and per-phase watchdog; abort outranks start and done.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset_n) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_INIT;
                        r_wdog  <= '0;
                    end
                end
                S_INIT, S_KSA, S_PRGA: begin
                    if (w_own_done) begin
                        r_state <= w_next_phase;
                        r_wdog  <= '0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wdog  <= r_wdog + 1'b1;
                    end
                end
                S_ERR:   ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Decode engine resets, status and the zero-latency memory port mux from state;
    // while reset is asserted everything is forced to its idle value immediately.
    always_comb begin
        init_rst = 1'b1;
        ksa_rst  = 1'b1;
        prga_rst = 1'b1;
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        phase    = 3'd0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        if (!reset_n) begin
            phase = r_state;
            busy  = (r_state == S_INIT) || (r_state == S_KSA) || (r_state == S_PRGA);
            done  = (r_state == S_DONE);
            error = (r_state == S_ERR);
            case (r_state)
                S_INIT: begin
                    init_rst = 1'b0;
                    mem_addr = init_addr;
                    mem_data = init_data;
                    mem_wren = init_wren;
                end
                S_KSA: begin
                    ksa_rst  = 1'b0;
                    mem_addr = ksa_addr;
                    mem_data = ksa_data;
                    mem_wren = ksa_wren;
                end
                S_PRGA: begin
                    prga_rst = 1'b0;
                    mem_addr = prga_addr;
                    mem_data = prga_data;
                    mem_wren = prga_wren;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Directed bench for rc4_phase_ctrl: a default-timeout instance for long phases
// and mux checks, and a TIMEOUT=16 instance for watchdog corner cases.
module tb_rc4_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, start, abort;
    logic [7:0] init_addr, init_data, ksa_addr, ksa_data, prga_addr, prga_data;
    logic       init_wren, init_done, ksa_wren, ksa_done, prga_wren, prga_done;

    logic       a_init_rst, a_ksa_rst, a_prga_rst, a_mem_wren, a_busy, a_done, a_error;
    logic [7:0] a_mem_addr, a_mem_data;
    logic [2:0] a_phase;
    logic       b_init_rst, b_ksa_rst, b_prga_rst, b_mem_wren, b_busy, b_done, b_error;
    logic [7:0] b_mem_addr, b_mem_data;
    logic [2:0] b_phase;

    int n_pass  = 0;
    int n_total = 0;
    int cur_ph  = 0;

    always #5 clk = ~clk;

    rc4_phase_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .init_rst(a_init_rst), .init_addr(init_addr), .init_data(init_data),
        .init_wren(init_wren), .init_done(init_done),
        .ksa_rst(a_ksa_rst), .ksa_addr(ksa_addr), .ksa_data(ksa_data),
        .ksa_wren(ksa_wren), .ksa_done(ksa_done),
        .prga_rst(a_prga_rst), .prga_addr(prga_addr), .prga_data(prga_data),
        .prga_wren(prga_wren), .prga_done(prga_done),
        .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_wren(a_mem_wren),
        .phase(a_phase), .busy(a_busy), .done(a_done), .error(a_error)
    );

    rc4_phase_ctrl #(.TIMEOUT(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .init_rst(b_init_rst), .init_addr(init_addr), .init_data(init_data),
        .init_wren(init_wren), .init_done(init_done),
        .ksa_rst(b_ksa_rst), .ksa_addr(ksa_addr), .ksa_data(ksa_data),
        .ksa_wren(ksa_wren), .ksa_done(ksa_done),
        .prga_rst(b_prga_rst), .prga_addr(prga_addr), .prga_data(prga_data),
        .prga_wren(prga_wren), .prga_done(prga_done),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
        .phase(b_phase), .busy(b_busy), .done(b_done), .error(b_error)
    );

    typedef struct {
        logic [2:0] ph;
        logic [7:0] ia, id; logic iw;
        logic [7:0] ka, kd; logic kw;
        logic [7:0] pa, pd; logic pw;
        logic [2:0] exp_rst;     // {init_rst, ksa_rst, prga_rst}
        logic [7:0] exp_addr, exp_data;
        logic       exp_wren;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0;
        init_addr = 0; init_data = 0; init_wren = 0; init_done = 0;
        ksa_addr  = 0; ksa_data  = 0; ksa_wren  = 0; ksa_done  = 0;
        prga_addr = 0; prga_data = 0; prga_wren = 0; prga_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b1;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        cur_ph = 0;
    endtask

    // Walk both instances forward one phase per pulse until the target phase.
    task automatic go_to(input int target);
        while (cur_ph < target) begin
            case (cur_ph)
                0: start     = 1'b1;
                1: init_done = 1'b1;
                2: ksa_done  = 1'b1;
                default: prga_done = 1'b1;
            endcase
            step();
            start = 0; init_done = 0; ksa_done = 0; prga_done = 0;
            cur_ph++;
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, " phase"}, 32'(a_phase), 32'd0);
        check({tag, " rsts"},  32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'b111);
        check({tag, " mem"},   32'({a_mem_addr, a_mem_data, a_mem_wren}), 32'd0);
        check({tag, " flags"}, 32'({a_busy, a_done, a_error}), 32'b000);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        //                 ph    ia     id     iw  ka     kd     kw  pa     pd     pw  rst     addr   data   wren
        vecs[0] = '{3'd0, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b111, 8'h00, 8'h00, 0};
        vecs[1] = '{3'd1, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b011, 8'h2A, 8'h11, 1};
        vecs[2] = '{3'd1, 8'h2B, 8'h12, 0, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b011, 8'h2B, 8'h12, 0};
        vecs[3] = '{3'd2, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b101, 8'h55, 8'h22, 1};
        vecs[4] = '{3'd2, 8'h2A, 8'h11, 1, 8'h56, 8'h23, 0, 8'h77, 8'h33, 1, 3'b101, 8'h56, 8'h23, 0};
        vecs[5] = '{3'd3, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b110, 8'h77, 8'h33, 1};
        vecs[6] = '{3'd3, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'hFF, 8'h00, 0, 3'b110, 8'hFF, 8'h00, 0};
        vecs[7] = '{3'd4, 8'h2A, 8'h11, 1, 8'h55, 8'h22, 1, 8'h77, 8'h33, 1, 3'b111, 8'h00, 8'h00, 0};

        // T1: full sequence with long phases on the default-timeout instance.
        do_reset();
        check_idle_a("t1_reset");
        start = 1'b1; step(); start = 1'b0;
        check("t1_init_phase", 32'(a_phase), 32'd1);
        check("t1_init_rsts", 32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'b011);
        check("t1_init_busy", 32'(a_busy), 32'd1);
        repeat (255) step();
        check("t1_init_hold", 32'(a_phase), 32'd1);
        init_done = 1'b1; step(); init_done = 1'b0;
        check("t1_ksa_phase", 32'(a_phase), 32'd2);
        check("t1_ksa_rsts", 32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'b101);
        init_done = 1'b1; prga_done = 1'b1; step(); init_done = 1'b0; prga_done = 1'b0;
        check("t1_foreign_done_ignored", 32'(a_phase), 32'd2);
        repeat (766) step();
        ksa_done = 1'b1; step(); ksa_done = 1'b0;
        check("t1_prga_phase", 32'(a_phase), 32'd3);
        check("t1_prga_rsts", 32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'b110);
        repeat (99) step();
        prga_done = 1'b1; step(); prga_done = 1'b0;
        check("t1_done_phase", 32'(a_phase), 32'd4);
        check("t1_done_flags", 32'({a_busy, a_done, a_error}), 32'b010);
        check("t1_done_rsts", 32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'b111);
        step();
        check("t1_done_hold", 32'(a_phase), 32'd4);

        // T2 and mux table: walk through every phase applying engine-port vectors.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            go_to(int'(vecs[i].ph));
            init_addr = vecs[i].ia; init_data = vecs[i].id; init_wren = vecs[i].iw;
            ksa_addr  = vecs[i].ka; ksa_data  = vecs[i].kd; ksa_wren  = vecs[i].kw;
            prga_addr = vecs[i].pa; prga_data = vecs[i].pd; prga_wren = vecs[i].pw;
            #1;
            check($sformatf("vec%0d_phase", i), 32'(a_phase), 32'(vecs[i].ph));
            check($sformatf("vec%0d_rsts", i), 32'({a_init_rst, a_ksa_rst, a_prga_rst}), 32'(vecs[i].exp_rst));
            check($sformatf("vec%0d_addr", i), 32'(a_mem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_data", i), 32'(a_mem_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_wren", i), 32'(a_mem_wren), 32'(vecs[i].exp_wren));
        end

        // T3: KSA watchdog on the TIMEOUT=16 instance; ERR is sticky until abort.
        do_reset();
        go_to(2);
        ksa_wren = 1'b1;
        repeat (15) step();
        check("t3_ksa_before_timeout", 32'(b_phase), 32'd2);
        step();
        check("t3_err_phase", 32'(b_phase), 32'd5);
        check("t3_err_flags", 32'({b_busy, b_done, b_error}), 32'b001);
        check("t3_err_rsts", 32'({b_init_rst, b_ksa_rst, b_prga_rst}), 32'b111);
        check("t3_err_no_wren", 32'(b_mem_wren), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("t3_start_ignored", 32'(b_phase), 32'd5);
        abort = 1'b1; step(); abort = 1'b0;
        check("t3_abort_phase", 32'(b_phase), 32'd0);
        check("t3_abort_error", 32'(b_error), 32'd0);

        // T4: done arriving on the last watchdog cycle of PRGA wins.
        do_reset();
        go_to(3);
        repeat (15) step();
        check("t4_prga_last_cycle", 32'(b_phase), 32'd3);
        prga_done = 1'b1; step(); prga_done = 1'b0;
        check("t4_done_wins", 32'(b_phase), 32'd4);

        // T5: abort beats prga_done; abort beats start in IDLE.
        do_reset();
        go_to(3);
        abort = 1'b1; prga_done = 1'b1; step(); abort = 1'b0; prga_done = 1'b0;
        check_idle_a("t5_abort_over_done");
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        check("t5_abort_over_start", 32'(a_phase), 32'd0);

        // T6: reset mid-KSA blocks the write at once, then a DONE restart gets a fresh watchdog.
        do_reset();
        go_to(2);
        ksa_wren = 1'b1; ksa_addr = 8'h3C;
        #1;
        check("t6_ksa_wren_live", 32'(a_mem_wren), 32'd1);
        reset_n = 1'b1;
        #1;
        check_idle_a("t6_reset_same_cycle");
        step();
        reset_n = 1'b0;
        ksa_wren = 1'b0;
        cur_ph = 0;
        #1;
        check_idle_a("t6_after_reset");
        go_to(2);
        repeat (10) step();
        go_to(4);
        check("t6_b_in_done", 32'(b_phase), 32'd4);
        start = 1'b1; step(); start = 1'b0;
        check("t6_restart_init", 32'(b_phase), 32'd1);
        repeat (15) step();
        check("t6_fresh_wdog_hold", 32'(b_phase), 32'd1);
        step();
        check("t6_fresh_wdog_expire", 32'(b_phase), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
